mem_stage: RTL

//  Memory-access stage between the EX/MEM and MEM/WB pipeline registers.

---
 rtl/mem_stage.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   Memory-access pipeline stage sitting between the EX/MEM and MEM/WB
//   registers. Each load or store is run as one transaction on a
//   variable-latency data-memory bus. The stage stalls the pipeline until the
//   transaction finishes, then formats load data (lane select and sign/zero
//   extension) into LoadData_M.
//
// Ports
//   CLK, RST        clock; synchronous active-high reset
//   MRE_X, MWE_X    load / store request from EX/MEM (load wins if both set)
//   Size_X, Uns_X   access size (00 byte, 01 half, 1x word) and zero-extend flag
//   Addr_X, WData_X byte address and right-aligned store data
//   DREQ, DWE       bus request and write flag
//   DADDR, DBE      word-aligned address and byte-lane enables
//   DWDATA          lane-replicated store data
//   DACK, DRDATA    bus acknowledge and read data (valid in the DACK cycle)
//   LoadData_M      registered, formatted load result
//   STALL           freeze upstream pipeline registers this cycle
//   MisAlign        one-cycle pulse: misaligned access dropped
//   BusErr          one-cycle pulse: access timed out
//   state_dbg       current FSM state (IDLE=0, BUSY=1, DONE=2)
//
// Bus handshake: DREQ rises on the edge leaving IDLE and stays high, with
// DWE/DADDR/DBE/DWDATA unchanged, until a cycle in which DACK=1 is sampled
// (or the timeout expires). The transfer completes on that edge and DREQ
// drops. DACK sampled while DREQ is low is ignored.
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              MRE_X,
  input  logic              MWE_X,
  input  logic [1:0]        Size_X,
  input  logic              Uns_X,
  input  logic [31:0]       Addr_X,
  input  logic [31:0]       WData_X,
  output logic              DREQ,
  output logic              DWE,
  output logic [ADDR_W-1:0] DADDR,
  output logic [3:0]        DBE,
  output logic [31:0]       DWDATA,
  input  logic              DACK,
  input  logic [31:0]       DRDATA,
  output logic [31:0]       LoadData_M,
  output logic              STALL,
  output logic              MisAlign,
  output logic              BusErr,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0] cnt;

  // Access attributes captured at issue so load formatting does not depend
  // on the EX/MEM register staying frozen.
  logic       ld_is_load;
  logic [1:0] ld_size;
  logic       ld_uns;
  logic [1:0] ld_lane;

  logic        acc;
  logic        is_load;
  logic [1:0]  lane;
  logic        misaligned;
  logic        issue;
  logic        timeout_hit;
  logic [3:0]  st_dbe;
  logic [3:0]  req_dbe;
  logic [31:0] st_wdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] fmt_data;

  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  always_comb begin
    acc        = MRE_X | MWE_X;
    is_load    = MRE_X;
    lane       = Addr_X[1:0];
    misaligned = ((Size_X == 2'b01) && lane[0]) ||
                 (Size_X[1] && (lane != 2'b00));
    issue      = acc & ~misaligned;
  end

  always_comb begin
    st_dbe   = 4'b1111;
    st_wdata = WData_X;
    case (Size_X)
      2'b00: begin
        st_dbe   = 4'b0001 << lane;
        st_wdata = {4{WData_X[7:0]}};
      end
      2'b01: begin
        st_dbe   = lane[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{WData_X[15:0]}};
      end
      default: begin
        st_dbe   = 4'b1111;
        st_wdata = WData_X;
      end
    endcase
    req_dbe = is_load ? 4'b1111 : st_dbe;
  end

  // ---------------------------------------------------------------------------
  // Load formatting from the captured size/lane/extension
  // ---------------------------------------------------------------------------
  always_comb begin
    case (ld_lane)
      2'd0:    byte_sel = DRDATA[7:0];
      2'd1:    byte_sel = DRDATA[15:8];
      2'd2:    byte_sel = DRDATA[23:16];
      default: byte_sel = DRDATA[31:24];
    endcase
    half_sel = ld_lane[1] ? DRDATA[31:16] : DRDATA[15:0];
    case (ld_size)
      2'b00:   fmt_data = {{24{~ld_uns & byte_sel[7]}}, byte_sel};
      2'b01:   fmt_data = {{16{~ld_uns & half_sel[15]}}, half_sel};
      default: fmt_data = DRDATA;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    STALL      = 1'b0;
    case (state)
      IDLE: begin
        if (issue) begin
          state_next = BUSY;
          STALL      = 1'b1;
        end
      end
      BUSY: begin
        STALL = 1'b1;
        if (DACK || timeout_hit) state_next = DONE;
      end
      DONE: begin
        // Pipeline advances on this edge; the completed instruction is not
        // re-examined.
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (RST) STALL = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Bus and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      DREQ       <= 1'b0;
      DWE        <= 1'b0;
      DADDR      <= '0;
      DBE        <= 4'b0000;
      DWDATA     <= 32'h0;
      LoadData_M <= 32'h0;
      MisAlign   <= 1'b0;
      BusErr     <= 1'b0;
      cnt        <= '0;
      ld_is_load <= 1'b0;
      ld_size    <= 2'b00;
      ld_uns     <= 1'b0;
      ld_lane    <= 2'b00;
    end else begin
      MisAlign <= 1'b0;
      BusErr   <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (acc && misaligned) begin
            MisAlign   <= 1'b1;
            LoadData_M <= 32'h0;
          end else if (issue) begin
            DREQ       <= 1'b1;
            DWE        <= ~is_load;
            DADDR      <= {Addr_X[ADDR_W-1:2], 2'b00};
            DBE        <= req_dbe;
            DWDATA     <= st_wdata;
            ld_is_load <= is_load;
            ld_size    <= Size_X;
            ld_uns     <= Uns_X;
            ld_lane    <= lane;
          end
        end
        BUSY: begin
          if (DACK) begin
            DREQ       <= 1'b0;
            cnt        <= '0;
            LoadData_M <= ld_is_load ? fmt_data : 32'h0;
          end else if (timeout_hit) begin
            DREQ       <= 1'b0;
            cnt        <= '0;
            BusErr     <= 1'b1;
            LoadData_M <= 32'h0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
